// File: rtl/sysbus_pkg.sv
// Shared types for the SysBus memory responder: FSM state encoding and strobe decode.
package sysbus_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    RespIdle  = 2'd0,
    RespRead  = 2'd1,
    RespWrite = 2'd2
  } resp_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic bad;
  } strobe_t;

  function automatic strobe_t decode_strobes(input logic nme, input logic noe, input logic nwe);
    strobe_t s;
    s.rd  = !nme & !noe &  nwe;
    s.wr  = !nme &  noe & !nwe;
    s.bad = !nme & !noe & !nwe;
    return s;
  endfunction

endpackage

// File: rtl/sysbus_ram.sv
// Single-port-pair synchronous RAM: one write port, one registered read port, no reset.
module sysbus_ram #(
  parameter int AddrBits = 10,
  parameter int DataW    = 16
) (
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [AddrBits-1:0] i_wr_addr,
  input  logic [DataW-1:0]    i_wr_data,
  input  logic                i_rd_en,
  input  logic [AddrBits-1:0] i_rd_addr,
  output logic [DataW-1:0]    o_rd_data
);

  logic [DataW-1:0] r_mem [2**AddrBits];
  logic [DataW-1:0] r_rd_data;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; returns old data on a same-address write
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: latches the address on ALE, serves reads and commits
// writes against an internal RAM window starting at BaseAddr.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int               DataW    = DATA_W,
  parameter int               AddrBits = 10,
  parameter logic [DataW-1:0] BaseAddr = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DataW-1:0] i_sysbus,
  output logic [DataW-1:0] o_sysbus,
  output logic             o_sysbus_oe,
  input  logic             i_ale,
  input  logic             i_nme,
  input  logic             i_noe,
  input  logic             i_nwe,
  output logic             o_hit,
  output logic             o_prot_err
);

  resp_state_t         r_state;
  resp_state_t         w_state_nxt;
  logic [AddrBits-1:0] r_addr;
  logic                r_hit;
  logic                r_oe;
  logic [DataW-1:0]    r_out;
  logic                r_prot_err;

  strobe_t             w_strb;
  logic                w_wr_en;
  logic                w_load_out;
  logic                w_rd_en;
  logic [AddrBits-1:0] w_rd_addr;
  logic [DataW-1:0]    w_ram_rdata;
  logic                w_addr_hit;

  assign w_strb     = decode_strobes(i_nme, i_noe, i_nwe);
  assign w_addr_hit = (i_sysbus[DataW-1:AddrBits] == BaseAddr[DataW-1:AddrBits]);

  // The RAM is read ahead from the address being latched (or already held) so the
  // word is ready by the first RD edge, letting SysBusOe rise one cycle after RD.
  assign w_rd_addr = i_ale ? i_sysbus[AddrBits-1:0] : r_addr;
  assign w_rd_en   = i_ale | (r_state == RespIdle);

  // Next-state decode; ALE overrides every strobe and reset aborts any commit
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_load_out  = 1'b0;
    if (i_reset) begin
      w_state_nxt = RespIdle;
    end else if (i_ale) begin
      w_state_nxt = RespIdle;
    end else begin
      case (r_state)
        RespIdle: begin
          if (w_strb.rd && r_hit) begin
            w_state_nxt = RespRead;
            w_load_out  = 1'b1;
          end else if (w_strb.wr && r_hit) begin
            w_state_nxt = RespWrite;
            w_wr_en     = 1'b1;
          end else begin
            w_state_nxt = RespIdle;
          end
        end
        RespRead: begin
          if (w_strb.rd) begin
            w_state_nxt = RespRead;
          end else begin
            w_state_nxt = RespIdle;
          end
        end
        RespWrite: begin
          if (w_strb.wr) begin
            w_state_nxt = RespWrite;
          end else begin
            w_state_nxt = RespIdle;
          end
        end
        default: begin
          w_state_nxt = RespIdle;
        end
      endcase
    end
  end

  // State, address latch, sticky protocol error and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= RespIdle;
      r_addr     <= {AddrBits{1'b0}};
      r_hit      <= 1'b0;
      r_oe       <= 1'b0;
      r_out      <= {DataW{1'b0}};
      r_prot_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_oe    <= (w_state_nxt == RespRead);
      if (i_ale) begin
        r_addr <= i_sysbus[AddrBits-1:0];
        r_hit  <= w_addr_hit;
      end
      if (w_load_out) begin
        r_out <= w_ram_rdata;
      end
      if (!i_ale && w_strb.bad) begin
        r_prot_err <= 1'b1;
      end
    end
  end

  sysbus_ram #(
    .AddrBits (AddrBits),
    .DataW    (DataW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_addr),
    .i_wr_data (i_sysbus),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_rdata)
  );

  assign o_sysbus    = r_out;
  assign o_sysbus_oe = r_oe;
  assign o_hit       = r_hit;
  assign o_prot_err  = r_prot_err;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scenario bench for sysbus_mem_responder with a reference memory model and read-data scoreboard.
module tb_sysbus_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        ale;
  logic        nme;
  logic        noe;
  logic        nwe;
  logic        hit;
  logic        prot_err;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model [int];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  sysbus_mem_responder #(
    .DataW    (16),
    .AddrBits (10),
    .BaseAddr (16'h0000)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_sysbus    (bus_in),
    .o_sysbus    (bus_out),
    .o_sysbus_oe (bus_oe),
    .i_ale       (ale),
    .i_nme       (nme),
    .i_noe       (noe),
    .i_nwe       (nwe),
    .o_hit       (hit),
    .o_prot_err  (prot_err)
  );

  // One bus cycle: drive, take the edge, settle to observe registered results
  task automatic step(input logic a, input logic me, input logic oe, input logic we, input logic [15:0] d);
    ale = a; nme = me; noe = oe; nwe = we; bus_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    step(1'b1, 1'b1, 1'b1, 1'b1, addr);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, data);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    if (addr < 16'h0400) model[int'(addr[9:0])] = data;
  endtask

  // Fetch-style read; reports how many cycles Oe was seen and the first driven word
  task automatic bus_read(input logic [15:0] addr, output int oe_cycles, output logic [15:0] data);
    oe_cycles = 0;
    data = 16'hxxxx;
    step(1'b1, 1'b1, 1'b1, 1'b1, addr);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    if (bus_oe === 1'b1) begin oe_cycles++; data = bus_out; end
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    if (bus_oe === 1'b1) oe_cycles++;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    if (bus_oe === 1'b1) oe_cycles++;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    if (bus_oe === 1'b1) oe_cycles++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", bus_oe); end
    checks++; if (bus_out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", bus_out); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL reset_prot got=%b exp=0", prot_err); end
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic test_fetch_read();
    int n;
    logic [15:0] d, e;
    bus_write(16'h0005, 16'hBEEF);
    exp_q.push_back(model[5]);
    bus_read(16'h0005, n, d);
    e = exp_q.pop_front();
    checks++; if (n != 2) begin errors++; $display("FAIL fetch_oe_cycles got=%0d exp=2", n); end
    checks++; if (d !== e) begin errors++; $display("FAIL fetch_data got=%h exp=%h", d, e); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL fetch_hit got=%b exp=1", hit); end
  endtask

  task automatic test_store_load();
    int n;
    logic [15:0] d, e;
    bus_write(16'h0010, 16'h1234);
    exp_q.push_back(model[16]);
    bus_read(16'h0010, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e || n != 2) begin errors++; $display("FAIL store_load got=%h/%0d exp=%h/2", d, n, e); end
    // Held WR strobe with changing data: only the first word may commit
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hBBBB);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hCCCC);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    model[32] = 16'hAAAA;
    exp_q.push_back(model[32]);
    bus_read(16'h0020, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL held_write_single got=%h exp=%h", d, e); end
  endtask

  task automatic test_miss();
    int n;
    logic [15:0] d, e;
    bus_write(16'h0000, 16'h5A5A);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0400);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got=%b exp=0", hit); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL miss_rd_oe got=%b exp=0", bus_oe); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL miss_wr_oe got=%b exp=0", bus_oe); end
    exp_q.push_back(model[0]);
    bus_read(16'h0000, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL miss_ram_untouched got=%h exp=%h", d, e); end
  endtask

  task automatic test_prot_err();
    int n;
    logic [15:0] d, e;
    bus_write(16'h0001, 16'h1111);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h2222);
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_set got=%b exp=1", prot_err); end
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL prot_oe got=%b exp=0", bus_oe); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    exp_q.push_back(model[1]);
    bus_read(16'h0001, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL prot_no_write got=%h exp=%h", d, e); end
    checks++; if (prot_err !== 1'b1) begin errors++; $display("FAIL prot_sticky got=%b exp=1", prot_err); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    logic [15:0] d, e;
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0005);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    checks++; if (bus_oe !== 1'b1) begin errors++; $display("FAIL midrd_oe_before got=%b exp=1", bus_oe); end
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    reset = 1'b0;
    checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL midrd_oe_after got=%b exp=0", bus_oe); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL midrd_prot got=%b exp=0", prot_err); end
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    exp_q.push_back(model[5]);
    bus_read(16'h0005, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e || n != 2) begin errors++; $display("FAIL midrd_recover got=%h/%0d exp=%h/2", d, n, e); end
  endtask

  task automatic test_ale_during_write();
    int n;
    logic [15:0] d, e;
    bus_write(16'h0030, 16'h0A0A);
    bus_write(16'h0031, 16'h0B0B);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0030);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h7777);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0031);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    model[48] = 16'h7777;
    exp_q.push_back(model[49]);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    e = exp_q.pop_front();
    checks++; if (bus_oe !== 1'b1 || bus_out !== e) begin errors++; $display("FAIL ale_wr_newaddr got=%b/%h exp=1/%h", bus_oe, bus_out, e); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    exp_q.push_back(model[48]);
    bus_read(16'h0030, n, d);
    e = exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL ale_wr_oldaddr got=%h exp=%h", d, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [15:0] d, e;
    logic [15:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = (i == 7) ? 16'h03FF : 16'(16'h0100 + i * 37);
      bus_write(addrs[i], 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model[int'(addrs[i][9:0])]);
      bus_read(addrs[i], n, d);
      e = exp_q.pop_front();
      checks++; if (d !== e || n != 2) begin errors++; $display("FAIL b2b_read[%0d] addr=%h got=%h/%0d exp=%h/2", i, addrs[i], d, n, e); end
    end
  endtask

  initial begin
    reset = 1'b0; ale = 1'b0; nme = 1'b1; noe = 1'b1; nwe = 1'b1; bus_in = 16'h0000;
    test_reset();
    test_fetch_read();
    test_store_load();
    test_miss();
    test_prot_err();
    test_reset_mid_read();
    test_ale_during_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
